fifo_wr_arb: RTL and testbench

Round-robin write-port arbiter sharing one FIFO write port (wdata/winc/wfull side) among NREQ requesters in the FPU result path. It grants one requester at a time for a burst of up to BURST words and drives the FIFO write strobe and data on that requester's behalf. It honours wfull backpressure and guarantees bounded wait for every requester. It sits entirely in the FIFO write-clock domain.

---
 rtl/fifo_wr_arb_if.sv | 29 ++
 rtl/fifo_wr_arb.sv | 98 +++++++++
 tb/tb_fifo_wr_arb.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_arb_if.sv
// Handshake bundle between the requesters, the write-port arbiter and the
// FIFO write side. The arbiter connects through the slave modport.
interface fifo_wr_arb_if #(
   parameter int NREQ  = 4,
   parameter int DSIZE = 8,
   parameter int IDW   = $clog2(NREQ)
);
   logic [NREQ-1:0]       req;
   logic [NREQ*DSIZE-1:0] req_wdata;
   logic [NREQ-1:0]       gnt;
   logic [NREQ-1:0]       ack;
   logic [IDW-1:0]        gnt_id;
   logic                  busy;
   logic [DSIZE-1:0]      fifo_wdata;
   logic                  fifo_winc;
   logic                  fifo_wfull;

   // requester / FIFO environment side
   modport master (
      output req, req_wdata, fifo_wfull,
      input  gnt, ack, gnt_id, busy, fifo_wdata, fifo_winc
   );

   // arbiter side
   modport slave (
      input  req, req_wdata, fifo_wfull,
      output gnt, ack, gnt_id, busy, fifo_wdata, fifo_winc
   );
endinterface

// File: rtl/fifo_wr_arb.sv
// Round-robin arbiter that shares one FIFO write port among NREQ requesters.
// A winner owns the port for up to BURST words, then the search pointer moves
// past it so every requester gets a turn.
module fifo_wr_arb #(
   parameter int NREQ  = 4,
   parameter int DSIZE = 8,
   parameter int BURST = 4,
   parameter int IDW   = $clog2(NREQ)
) (
   input  logic          clk,
   input  logic          rst_n,
   fifo_wr_arb_if.slave  bus
);
   typedef enum logic {ST_IDLE, ST_BURST} state_e;

   state_e            state_q, state_d;
   logic [IDW-1:0]    owner_q, owner_d;
   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [NREQ-1:0]   gnt_q, gnt_d;
   logic [IDW-1:0]    winner;
   logic              any_req;
   logic              own_req;
   logic              busy;
   logic              winc;

   // Round-robin pick: first set request at or after ptr, wrapping mod NREQ.
   // Scanning from the far end lets the nearest hit overwrite the others.
   always_comb begin
      logic [IDW-1:0] idx;
      idx     = '0;
      winner  = ptr_q;
      any_req = |bus.req;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = IDW'((int'(ptr_q) + k) % NREQ);
         if (bus.req[idx]) winner = idx;
      end
   end

   assign busy    = (state_q == ST_BURST);
   assign own_req = bus.req[owner_q];
   // rst_n gates the strobe so a reset edge never doubles as a FIFO write.
   assign winc    = busy & own_req & ~bus.fifo_wfull & rst_n;

   assign bus.busy       = busy;
   assign bus.gnt        = gnt_q;
   assign bus.gnt_id     = owner_q;
   assign bus.fifo_winc  = winc;
   assign bus.ack        = winc ? gnt_q : '0;
   assign bus.fifo_wdata = busy ? bus.req_wdata[int'(owner_q)*DSIZE +: DSIZE] : '0;

   // Next-state: grant from IDLE, count words in BURST, release on full burst
   // or when the owner drops its request (no write in that cycle).
   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      cnt_d   = cnt_q;
      gnt_d   = gnt_q;
      case (state_q)
         ST_IDLE: begin
            if (any_req) begin
               owner_d = winner;
               gnt_d   = NREQ'(1) << winner;
               cnt_d   = '0;
               state_d = ST_BURST;
            end
         end
         ST_BURST: begin
            if (!own_req || (winc && cnt_q == 4'(BURST - 1))) begin
               state_d = ST_IDLE;
               gnt_d   = '0;
               ptr_d   = (owner_q == IDW'(NREQ - 1)) ? '0 : owner_q + 1'b1;
            end else if (winc) begin
               cnt_d = cnt_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         owner_q <= '0;
         ptr_q   <= '0;
         cnt_q   <= '0;
         gnt_q   <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
      end
   end
endmodule

// File: tb/tb_fifo_wr_arb.sv
// Bench for fifo_wr_arb: directed scenarios followed by a long random run,
// all checked against a cycle-level behavioural model and a FIFO scoreboard.
module tb_fifo_wr_arb;
   localparam int NREQ  = 4;
   localparam int DSIZE = 8;
   localparam int BURST = 4;
   localparam int IDW   = $clog2(NREQ);
   localparam int BOUND = (NREQ - 1) * (BURST + 1) + 1;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   fifo_wr_arb_if #(.NREQ(NREQ), .DSIZE(DSIZE)) bus ();

   fifo_wr_arb #(.NREQ(NREQ), .DSIZE(DSIZE), .BURST(BURST)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk = 0;
   int n_err = 0;

   // model: owner index or -1 when idle, words written this burst, rr pointer
   int m_own = -1;
   int m_cnt = 0;
   int m_ptr = 0;
   int m_gid = 0;
   int seq [NREQ];
   int wt  [NREQ];
   int max_wt = 0;
   int nwr = 0;
   logic [DSIZE-1:0] fifo_q [$];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [DSIZE-1:0] word(input int i, input int s);
      return DSIZE'((i << 5) | (s & 31));
   endfunction

   task automatic drive_data();
      for (int i = 0; i < NREQ; i++) bus.req_wdata[i*DSIZE +: DSIZE] = word(i, seq[i]);
   endtask

   // One clock: check mid-cycle against the model, then advance model and
   // requesters across the edge. Inputs must already be driven.
   task automatic tick();
      logic [NREQ-1:0]  eg, ea, dack;
      logic             ew, dwinc;
      logic [DSIZE-1:0] ed, dwd;
      int nown, ncnt, nptr, ngid;
      bit ext;
      #4;
      ew = 1'b0;
      eg = '0;
      ed = '0;
      if (m_own >= 0) begin
         ew = bus.req[m_own] && !bus.fifo_wfull && rst_n;
         eg = NREQ'(1) << m_own;
         ed = word(m_own, seq[m_own]);
      end
      ea = ew ? eg : '0;
      chk("busy",   bus.busy, m_own >= 0);
      chk("gnt",    bus.gnt, eg);
      chk("gnt_id", bus.gnt_id, m_gid);
      chk("winc",   bus.fifo_winc, ew);
      chk("ack",    bus.ack, ea);
      chk("wdata",  bus.fifo_wdata, ed);
      chk("onehot", $onehot0(bus.gnt), 1);

      // wait tracking, stall cycles excluded
      for (int i = 0; i < NREQ; i++) begin
         if (!rst_n || !bus.req[i] || bus.gnt[i]) wt[i] = 0;
         else if (!(bus.busy && bus.fifo_wfull)) wt[i]++;
         if (wt[i] > max_wt) max_wt = wt[i];
      end

      nown = m_own; ncnt = m_cnt; nptr = m_ptr; ngid = m_gid; ext = 0;
      if (!rst_n) begin
         nown = -1; ncnt = 0; nptr = 0; ngid = 0;
      end else if (m_own < 0) begin
         for (int k = 0; k < NREQ; k++)
            if (nown < 0 && bus.req[(m_ptr + k) % NREQ]) nown = (m_ptr + k) % NREQ;
         if (nown >= 0) begin ngid = nown; ncnt = 0; end
      end else if (!bus.req[m_own]) begin
         ext = 1;
      end else if (ew) begin
         ncnt = m_cnt + 1;
         if (ncnt == BURST) ext = 1;
      end
      if (ext) begin nptr = (m_own + 1) % NREQ; nown = -1; end

      dack = bus.ack; dwinc = bus.fifo_winc; dwd = bus.fifo_wdata;
      @(posedge clk);
      #1;
      m_own = nown; m_cnt = ncnt; m_ptr = nptr; m_gid = ngid;
      if (dwinc) begin fifo_q.push_back(dwd); nwr++; end
      for (int i = 0; i < NREQ; i++) if (dack[i]) seq[i]++;
      drive_data();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.req = '0;
      bus.fifo_wfull = 1'b0;
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < NREQ; i++) begin seq[i] = 0; wt[i] = 0; end
      rst_n = 1'b0;
      bus.req = '0;
      bus.fifo_wfull = 1'b0;
      drive_data();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      tick();                                   // reset state checked here

      // single requester: 4 writes, idle, regrant
      do_reset();
      bus.req = 4'b0001;
      nwr = 0;
      repeat (6) tick();
      chk("t1_writes", nwr, 4);

      // all requesting: 16 writes in 20 cycles, order 0,1,2,3
      do_reset();
      bus.req = 4'b1111;
      nwr = 0;
      repeat (20) tick();
      chk("t2_writes", nwr, 16);

      // wfull stall mid-burst on owner 2
      do_reset();
      bus.req = 4'b0100;
      nwr = 0;
      for (int c = 0; c < 10; c++) begin
         bus.fifo_wfull = (c >= 2 && c <= 6);
         tick();
      end
      chk("t3_writes", nwr, 4);
      bus.fifo_wfull = 1'b0;

      // early release by owner 1, then requester 3 beats requester 0
      do_reset();
      bus.req = 4'b0010;
      repeat (3) tick();
      bus.req = 4'b1001;
      repeat (2) tick();
      chk("t4_gnt", bus.gnt, 4'b1000);

      // reset mid-burst, then grant search restarts at 0
      do_reset();
      bus.req = 4'b0010;
      repeat (7) tick();
      rst_n = 1'b0;
      #2;
      chk("t5_winc_rst", bus.fifo_winc, 0);
      tick();
      rst_n = 1'b1;
      bus.req = 4'b1001;
      tick();
      chk("t5_gnt", bus.gnt, 4'b0001);

      // random run
      for (int c = 0; c < 10000; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (bus.req[i]) begin
               if ($urandom_range(15) == 0) bus.req[i] = 1'b0;
            end else if ($urandom_range(1) == 1) begin
               bus.req[i] = 1'b1;
            end
         end
         bus.fifo_wfull = ($urandom_range(3) == 0);
         rst_n = ($urandom_range(499) != 0);
         tick();
      end

      // each requester's words appear in the FIFO in order, none lost or doubled
      for (int i = 0; i < NREQ; i++) begin
         int  n;
         bit  ok;
         n = 0; ok = 1;
         foreach (fifo_q[j]) begin
            if (int'(fifo_q[j][7:5]) == i) begin
               if (int'(fifo_q[j][4:0]) != (n & 31)) ok = 0;
               n++;
            end
         end
         chk($sformatf("stream%0d_order", i), ok, 1);
         chk($sformatf("stream%0d_count", i), n, seq[i]);
      end
      chk("starvation_bound", max_wt <= BOUND, 1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
